mandelbrot_iterator: RTL and testbench

//  Downstream consumer of the pixel->complex mapper. Accepts one point c=(cr,ci) per job in signed
//  4.23 fixed point, plus the originating pixel tag (x,y). Iterates z <= z^2 + c from z=0 until

---
 rtl/mandelbrot_iterator_pkg.sv | 48 ++++
 rtl/mandelbrot_iterator_fix_mul.sv | 18 +
 rtl/mandelbrot_iterator.sv | 139 +++++++++++++
 tb/tb_mandelbrot_iterator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_iterator_pkg.sv
// rtl/mandelbrot_iterator_pkg.sv - shared types, constants and fixed-point helpers for the Mandelbrot iterator
package mandel_pkg;

  localparam int WIDTH  = 27;
  localparam int FRAC   = 23;
  localparam int ITER_W = 10;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef logic signed [WIDTH-1:0]   fix_t;
  typedef logic signed [WIDTH+1:0]   wide_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;

  localparam fix_t FIX_TWO     = fix_t'(2 << FRAC);
  localparam fix_t FIX_NEG_TWO = fix_t'(-(2 << FRAC));
  localparam fix_t FIX_FOUR    = fix_t'(4 << FRAC);

  // Saturation bounds of a fix_t, expressed in the wider next-z sum format
  localparam wide_t WIDE_MAX = wide_t'((1 << (WIDTH-1)) - 1);
  localparam wide_t WIDE_MIN = wide_t'(-(1 << (WIDTH-1)));

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } iter_state_t;

  // Arithmetic shift right by FRAC then keep WIDTH bits (truncates toward -inf)
  function automatic fix_t fix_trunc(input prod_t p);
    return p[FRAC +: WIDTH];
  endfunction

  // Sign-extend a fix_t into the next-z sum format
  function automatic wide_t sext2(input fix_t v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  // Clamp a wide sum into the fix_t range so overflow never wraps
  function automatic fix_t fix_sat(input wide_t v);
    if (v > WIDE_MAX) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v < WIDE_MIN) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end
    return fix_t'(v);
  endfunction

endpackage

// File: rtl/mandelbrot_iterator_fix_mul.sv
// rtl/mandelbrot_iterator_fix_mul.sv - signed fixed-point multiplier with truncating rescale
module fix_mul
  import mandel_pkg::*;
(
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] p_o
);

  prod_t prod;

  // Full-width signed product, rescaled back to the 4.23 format
  always_comb begin
    prod = a_i * b_i;
    p_o  = fix_trunc(prod);
  end

endmodule

// File: rtl/mandelbrot_iterator.sv
// rtl/mandelbrot_iterator.sv - one-job-at-a-time z <= z^2 + c escape-time iterator
module mandelbrot_iterator
  import mandel_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  cr,
  input  logic signed [WIDTH-1:0]  ci,
  input  logic [X_W-1:0]           x_in,
  input  logic [Y_W-1:0]           y_in,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ITER_W-1:0]        out_iter,
  output logic [X_W-1:0]           out_x,
  output logic [Y_W-1:0]           out_y,
  output logic                     busy
);

  iter_state_t         state_q, state_d;
  fix_t                zr_q, zr_d, zi_q, zi_d;
  fix_t                cr_q, cr_d, ci_q, ci_d;
  logic [ITER_W-1:0]   max_iter_q, max_iter_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   out_iter_q, out_iter_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                out_valid_q, out_valid_d;

  fix_t                zr2, zi2, zrzi;
  logic signed [WIDTH:0] mag2;
  wide_t               zr_sum, zi_sum;
  logic                esc;

  fix_mul u_mul_rr (.a_i(zr_q), .b_i(zr_q), .p_o(zr2));
  fix_mul u_mul_ii (.a_i(zi_q), .b_i(zi_q), .p_o(zi2));
  fix_mul u_mul_ri (.a_i(zr_q), .b_i(zi_q), .p_o(zrzi));

  // Escape test and candidate next z from the current z and the latched c
  always_comb begin
    mag2   = {zr2[WIDTH-1], zr2} + {zi2[WIDTH-1], zi2};
    esc    = (zr_q >= FIX_TWO) || (zr_q <= FIX_NEG_TWO) ||
             (zi_q >= FIX_TWO) || (zi_q <= FIX_NEG_TWO) ||
             (mag2 >= $signed({1'b0, FIX_FOUR}));
    zr_sum = sext2(zr2) - sext2(zi2) + sext2(cr_q);
    zi_sum = sext2(zrzi) + sext2(zrzi) + sext2(ci_q);
  end

  // Next-state and datapath updates; out_valid follows one cycle after DONE entry
  always_comb begin
    state_d     = state_q;
    zr_d        = zr_q;
    zi_d        = zi_q;
    cr_d        = cr_q;
    ci_d        = ci_q;
    max_iter_d  = max_iter_q;
    iter_d      = iter_q;
    out_iter_d  = out_iter_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cr_d       = cr;
          ci_d       = ci;
          x_d        = x_in;
          y_d        = y_in;
          max_iter_d = max_iter;
          zr_d       = '0;
          zi_d       = '0;
          iter_d     = '0;
          state_d    = ITER;
        end
      end
      ITER: begin
        if (esc || (iter_q == max_iter_q)) begin
          out_iter_d = iter_q;
          state_d    = DONE;
        end else begin
          zr_d   = fix_sat(zr_sum);
          zi_d   = fix_sat(zi_sum);
          iter_d = iter_q + 1'b1;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers; reset discards any job in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      zr_q        <= '0;
      zi_q        <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      max_iter_q  <= '0;
      iter_q      <= '0;
      out_iter_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zr_q        <= zr_d;
      zi_q        <= zi_d;
      cr_q        <= cr_d;
      ci_q        <= ci_d;
      max_iter_q  <= max_iter_d;
      iter_q      <= iter_d;
      out_iter_q  <= out_iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_iter  = out_iter_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// tb/tb_mandelbrot_iterator.sv - directed self-checking bench for mandelbrot_iterator
module tb_mandelbrot_iterator;

  localparam logic signed [26:0] C_ZERO  = 27'sd0;
  localparam logic signed [26:0] C_ONE   = 27'sh0800000;
  localparam logic signed [26:0] C_M_ONE = -27'sh0800000;
  localparam logic signed [26:0] C_THREE = 27'sh1800000;
  localparam logic signed [26:0] C_7P9   = 27'sd66270003;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [26:0] cr, ci;
  logic [9:0]        x_in;
  logic [8:0]        y_in;
  logic [9:0]        max_iter;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_iter;
  logic [9:0]        out_x;
  logic [8:0]        out_y;
  logic              busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mandelbrot_iterator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .cr(cr), .ci(ci), .x_in(x_in), .y_in(y_in), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_iter(out_iter),
    .out_x(out_x), .out_y(out_y), .busy(busy)
  );

  task automatic run_job(input logic signed [26:0] c_r, input logic signed [26:0] c_i,
                         input logic [9:0] x, input logic [8:0] y, input logic [9:0] mi,
                         output int lat, output bit to);
    @(negedge clk);
    cr = c_r; ci = c_i; x_in = x; y_in = y; max_iter = mi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    to  = 1'b0;
    while (!out_valid) begin
      if (lat >= 1100) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    cr = '0; ci = '0; x_in = '0; y_in = '0; max_iter = '0;
    #12;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    tests++;
    if (out_iter !== 10'd0 || out_x !== 10'd0 || out_y !== 9'd0) begin
      failed++;
      $display("FAIL reset_data: out_iter=%0d out_x=%0d out_y=%0d, want 0 0 0", out_iter, out_x, out_y);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_job(input string name, input logic signed [26:0] c_r, input logic signed [26:0] c_i,
                          input logic [9:0] x, input logic [8:0] y, input logic [9:0] mi,
                          input logic [9:0] exp_iter, input int exp_lat);
    int lat;
    bit to;
    run_job(c_r, c_i, x, y, mi, lat, to);
    tests++;
    if (to) begin
      failed++;
      $display("FAIL %s_timeout: no out_valid within %0d cycles", name, lat);
    end
    tests++;
    if (out_iter !== exp_iter) begin
      failed++;
      $display("FAIL %s_iter: got %0d, want %0d", name, out_iter, exp_iter);
    end
    tests++;
    if (lat != exp_lat) begin
      failed++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, exp_lat);
    end
    tests++;
    if (out_x !== x || out_y !== y) begin
      failed++;
      $display("FAIL %s_tag: got (%0d,%0d), want (%0d,%0d)", name, out_x, out_y, x, y);
    end
    take_result();
  endtask

  task automatic test_hold();
    int lat;
    bit to;
    run_job(C_ONE, C_ZERO, 10'd5, 9'd6, 10'd100, lat, to);
    tests++;
    if (to) begin
      failed++;
      $display("FAIL hold_timeout: no out_valid");
    end
    @(negedge clk);
    in_valid = 1'b1; cr = C_ZERO; ci = C_ZERO; x_in = 10'd1; y_in = 9'd1; max_iter = 10'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_iter !== 10'd2 || out_x !== 10'd5 || out_y !== 9'd6 || in_ready !== 1'b0) begin
        failed++;
        $display("FAIL hold_stable[%0d]: v=%b iter=%0d x=%0d y=%0d in_ready=%b, want 1 2 5 6 0",
                 i, out_valid, out_iter, out_x, out_y, in_ready);
      end
    end
    in_valid = 1'b0;
    take_result();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_latched_inputs();
    int lat;
    @(negedge clk);
    cr = C_ONE; ci = C_ZERO; x_in = 10'd7; y_in = 9'd8; max_iter = 10'd100; in_valid = 1'b1;
    @(posedge clk); #1;
    cr = C_ZERO; ci = C_THREE; x_in = 10'd9; y_in = 9'd9; max_iter = 10'd0; out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) out_ready = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (out_iter !== 10'd2 || lat != 4) begin
      failed++;
      $display("FAIL latched_job: iter=%0d lat=%0d, want 2 4", out_iter, lat);
    end
    tests++;
    if (out_x !== 10'd7 || out_y !== 9'd8) begin
      failed++;
      $display("FAIL latched_tag: got (%0d,%0d), want (7,8)", out_x, out_y);
    end
    take_result();
  endtask

  task automatic test_reset_mid_iter();
    @(negedge clk);
    cr = C_ZERO; ci = C_ZERO; x_in = 10'd3; y_in = 9'd4; max_iter = 10'd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (37) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    test_job("after_reset", C_ONE, C_ZERO, 10'd11, 9'd12, 10'd100, 10'd2, 4);
  endtask

  initial begin
    test_reset();
    test_job("zero",     C_ZERO,  C_ZERO,  10'd1,   9'd2,   10'd1000, 10'd1000, 1002);
    test_job("one",      C_ONE,   C_ZERO,  10'd639, 9'd479, 10'd100,  10'd2,    4);
    test_job("minus1",   C_M_ONE, C_ZERO,  10'd20,  9'd30,  10'd255,  10'd255,  257);
    test_job("three",    C_THREE, C_THREE, 10'd0,   9'd0,   10'd50,   10'd1,    3);
    test_job("maxzero",  C_ONE,   C_ZERO,  10'd100, 9'd200, 10'd0,    10'd0,    2);
    test_job("sat",      C_7P9,   C_7P9,   10'd321, 9'd123, 10'd10,   10'd1,    3);
    test_hold();
    test_latched_inputs();
    test_reset_mid_iter();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
